// File: rtl/sca_trigger_capture_pkg.sv
// Shared types for the capture-side trigger timestamping block.
package sca_trigger_capture_pkg;

  // Default timebase/length width; the top module defaults its CntW to this.
  localparam int unsigned TrigCntW = 32;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StInPulse = 2'd2
  } trig_state_e;

  // One captured pulse. The FIFO stores events packed in this field order.
  typedef struct packed {
    logic [TrigCntW-1:0] start;
    logic [TrigCntW-1:0] len;
    logic                trunc;
  } trig_event_t;

  // Packed width of an event for an arbitrary counter width.
  function automatic int unsigned event_width(input int unsigned cnt_w);
    return 2 * cnt_w + 1;
  endfunction

endpackage

// File: rtl/sca_trigger_event_fifo.sv
// First-word-fall-through event FIFO with synchronous reset and flush.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sca_trigger_event_fifo
  import sca_trigger_capture_pkg::*;
#(
  parameter int unsigned Width = $bits(trig_event_t),
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam logic [AW:0] PtrOne = 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             wr_en;
  logic             rd_en;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_en   = pop_i && !empty_o;
  assign wr_en   = push_i && (!full_o || rd_en);

  // Pointer update; flush behaves like a reset of the occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (rd_en) rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  // Storage write; contents need no reset since the head is masked when empty.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  assign data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/sca_trigger_capture.sv
// Samples the asynchronous AES trigger line, timestamps each pulse relative
// to an arm command and queues {start, len, trunc} for readout.
module sca_trigger_capture
  import sca_trigger_capture_pkg::*;
#(
  parameter int unsigned CntW       = TrigCntW,
  parameter int unsigned Depth      = 4,
  parameter int unsigned SyncStages = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            trigger_i,
  input  logic            arm_i,
  input  logic            disarm_i,
  input  logic            clr_i,
  input  logic [CntW-1:0] timeout_i,
  output logic            event_valid_o,
  input  logic            event_ready_i,
  output logic [CntW-1:0] event_start_o,
  output logic [CntW-1:0] event_len_o,
  output logic            event_trunc_o,
  output logic            armed_o,
  output logic            overflow_o,
  output logic            timeout_o
);

  localparam int unsigned EvW = event_width(CntW);

  logic [SyncStages-1:0] sync_q;
  logic                  trig_d_q;
  logic                  trig_s;
  logic                  rise;
  logic                  fall;

  trig_state_e           state_q;
  logic [CntW-1:0]       timebase_q;
  logic [CntW-1:0]       tb_inc;
  logic [CntW-1:0]       start_q;
  logic [CntW-1:0]       len_q;
  logic                  seen_edge_q;
  logic                  armed_q;
  logic                  overflow_q;
  logic                  timeout_q;

  logic                  push_req;
  logic                  push_trunc;
  logic                  push_fifo;
  logic                  timeout_fire;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [EvW-1:0]        fifo_rdata;

  // Synchroniser chain plus one delay flop for edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q   <= '0;
      trig_d_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SyncStages-2:0], trigger_i};
      trig_d_q <= trig_s;
    end
  end

  assign trig_s = sync_q[SyncStages-1];
  assign rise   = trig_s & ~trig_d_q;
  assign fall   = ~trig_s & trig_d_q;
  assign tb_inc = (timebase_q == '1) ? timebase_q : timebase_q + CntW'(1);

  // Decode event pushes and the timeout so the event lands in the FIFO at
  // the end of the detecting cycle. A re-arm discards an open pulse.
  always_comb begin
    push_req     = 1'b0;
    push_trunc   = 1'b0;
    timeout_fire = 1'b0;
    if (!arm_i) begin
      if (state_q == StInPulse) begin
        if (disarm_i) begin
          push_req   = 1'b1;
          push_trunc = ~fall;
        end else if (fall) begin
          push_req = 1'b1;
        end
      end else if (state_q == StArmed && !disarm_i && !rise) begin
        timeout_fire = (timeout_i != '0) && !seen_edge_q &&
                       (timebase_q == timeout_i - CntW'(1));
      end
    end
  end

  assign push_fifo = push_req && !clr_i;

  // Capture FSM with timebase and pulse-length counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      timebase_q  <= '0;
      start_q     <= '0;
      len_q       <= '0;
      seen_edge_q <= 1'b0;
      armed_q     <= 1'b0;
    end else if (arm_i) begin
      state_q     <= StArmed;
      timebase_q  <= '0;
      seen_edge_q <= 1'b0;
      armed_q     <= 1'b1;
    end else begin
      case (state_q)
        StArmed: begin
          timebase_q <= tb_inc;
          if (disarm_i || timeout_fire) begin
            state_q <= StIdle;
            armed_q <= 1'b0;
          end else if (rise) begin
            state_q     <= StInPulse;
            start_q     <= timebase_q;
            len_q       <= CntW'(1);
            seen_edge_q <= 1'b1;
          end
        end
        StInPulse: begin
          timebase_q <= tb_inc;
          if (disarm_i) begin
            state_q <= StIdle;
            armed_q <= 1'b0;
          end else if (fall) begin
            state_q <= StArmed;
          end else if (trig_s && len_q != '1) begin
            len_q <= len_q + CntW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Sticky flags; a new timeout in the clearing cycle still sets the flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      if (clr_i) begin
        overflow_q <= 1'b0;
        timeout_q  <= 1'b0;
      end
      if (timeout_fire) timeout_q <= 1'b1;
      if (push_fifo && fifo_full && !event_ready_i) overflow_q <= 1'b1;
    end
  end

  sca_trigger_event_fifo #(
    .Width(EvW),
    .Depth(Depth)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .flush_i(clr_i),
    .push_i (push_fifo),
    .data_i ({start_q, len_q, push_trunc}),
    .pop_i  (event_ready_i),
    .data_o (fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign {event_start_o, event_len_o, event_trunc_o} = fifo_rdata;
  assign event_valid_o = ~fifo_empty;
  assign armed_o       = armed_q;
  assign overflow_o    = overflow_q;
  assign timeout_o     = timeout_q;

endmodule
